// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between the instruction-fetch
//             path and the data load/store path. One grant per cycle, data
//             side has priority, fetch is guaranteed a grant after MAX_WAIT
//             consecutive denied cycles. Read data is registered into a
//             per-requester response port one cycle after the grant.
//  Ports    : clk, rst_n (async, active low)
//             i_if_*  : fetch request / address;  o_if_* : grant, response
//             i_d_*   : data request, wr, addr, wdata; o_d_* : grant, response
//             o_pc_stall : holds the PC while fetch is requested but denied
//             o_mem_* / i_mem_data_out : memory port (combinational read)
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_wr,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_pc_stall,
    output logic              o_mem_enable,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_in,
    input  logic [DATA_W-1:0] i_mem_data_out
);

    localparam int c_WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                w_if_gnt;
    logic                w_d_gnt;
    logic                w_fetch_forced;
    logic                r_if_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_d_rvalid;
    logic [DATA_W-1:0]   r_d_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and arbitration. INIT issues no grants; it gives the
    // memory one cycle to come out of its own reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_if_gnt       = 1'b0;
        w_d_gnt        = 1'b0;
        w_fetch_forced = i_if_req && (r_wait_cnt == c_WAIT_MAX);
        case (r_state)
            ST_INIT: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (i_d_req && !w_fetch_forced) begin
                    w_d_gnt = 1'b1;
                end else if (i_if_req) begin
                    w_if_gnt = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive denied fetch cycles and
    // saturates, so a forced fetch win is never lost to wrap-around.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (i_if_req && !w_if_gnt) begin
                if (r_wait_cnt != c_WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux; idle port drives all zeros.
    // ------------------------------------------------------------------
    always_comb begin
        o_mem_enable  = 1'b0;
        o_mem_wr      = 1'b0;
        o_mem_addr    = '0;
        o_mem_data_in = '0;
        if (w_if_gnt) begin
            o_mem_enable = 1'b1;
            o_mem_addr   = i_if_addr;
        end else if (w_d_gnt) begin
            o_mem_enable  = 1'b1;
            o_mem_wr      = i_d_wr;
            o_mem_addr    = i_d_addr;
            o_mem_data_in = i_d_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Response registers. Stores complete at the grant edge and produce
    // no rvalid; rdata holds until the next capture for that requester.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_d_rvalid  <= w_d_gnt && !i_d_wr;
            if (w_if_gnt) begin
                r_if_rdata <= i_mem_data_out;
            end
            if (w_d_gnt && !i_d_wr) begin
                r_d_rdata <= i_mem_data_out;
            end
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_if_rvalid = r_if_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rvalid  = r_d_rvalid;
    assign o_d_rdata   = r_d_rdata;
    // Gated by rst_n so the stall is forced low while reset is asserted.
    assign o_pc_stall  = rst_n && i_if_req && !w_if_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. A behavioural model
//             (denied-cycle count, shadow memory, expected responses) is
//             checked against the DUT every cycle; directed sequences add
//             literal expectations, then randomized traffic with resets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              pc_stall;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_if_req      (if_req),
        .i_if_addr     (if_addr),
        .o_if_gnt      (if_gnt),
        .o_if_rvalid   (if_rvalid),
        .o_if_rdata    (if_rdata),
        .i_d_req       (d_req),
        .i_d_wr        (d_wr),
        .i_d_addr      (d_addr),
        .i_d_wdata     (d_wdata),
        .o_d_gnt       (d_gnt),
        .o_d_rvalid    (d_rvalid),
        .o_d_rdata     (d_rdata),
        .o_pc_stall    (pc_stall),
        .o_mem_enable  (mem_enable),
        .o_mem_wr      (mem_wr),
        .o_mem_addr    (mem_addr),
        .o_mem_data_in (mem_data_in),
        .i_mem_data_out(mem_data_out)
    );

    // Environment memory standing in for memory2c (combinational read).
    logic [DATA_W-1:0] env_mem [0:255];
    assign mem_data_out = env_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_enable && mem_wr) env_mem[mem_addr[9:2]] <= mem_data_in;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] m_mem [0:255];
    bit                m_run   = 0;
    int                m_wait  = 0;   // consecutive denied fetch cycles
    bit                m_if_rv = 0;
    bit                m_d_rv  = 0;
    logic [DATA_W-1:0] m_if_rd = '0;
    logic [DATA_W-1:0] m_d_rd  = '0;

    // Returns {fetch_wins, data_wins} for the current inputs.
    function automatic logic [1:0] winner();
        if (!m_run) return 2'b00;
        if (d_req && !(if_req && m_wait >= MAX_WAIT)) return 2'b01;
        if (if_req) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        logic [1:0] w;
        if (!rst_n) begin
            m_run = 0; m_wait = 0;
            m_if_rv = 0; m_d_rv = 0; m_if_rd = '0; m_d_rd = '0;
        end else begin
            w = winner();
            m_if_rv = w[1];
            m_d_rv  = w[0] && !d_wr;
            if (w[1]) m_if_rd = m_mem[if_addr[9:2]];
            if (w[0] && !d_wr) m_d_rd = m_mem[d_addr[9:2]];
            if (w[0] && d_wr) m_mem[d_addr[9:2]] = d_wdata;
            if (m_run) begin
                if (if_req && !w[1]) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
                else m_wait = 0;
            end
            m_run = 1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [1:0] w;
        if (!rst_n) begin
            check("rst_if_gnt", {63'b0, if_gnt}, 64'd0);
            check("rst_d_gnt", {63'b0, d_gnt}, 64'd0);
            check("rst_pc_stall", {63'b0, pc_stall}, 64'd0);
            check("rst_mem_en", {63'b0, mem_enable}, 64'd0);
            check("rst_mem_wr", {63'b0, mem_wr}, 64'd0);
            check("rst_mem_addr", {32'b0, mem_addr}, 64'd0);
            check("rst_mem_din", {32'b0, mem_data_in}, 64'd0);
            check("rst_rvalids", {62'b0, if_rvalid, d_rvalid}, 64'd0);
            check("rst_rdatas", {if_rdata, d_rdata}, 64'd0);
        end else begin
            w = winner();
            check("if_gnt", {63'b0, if_gnt}, {63'b0, w[1]});
            check("d_gnt", {63'b0, d_gnt}, {63'b0, w[0]});
            check("pc_stall", {63'b0, pc_stall}, {63'b0, if_req && !w[1]});
            check("mem_enable", {63'b0, mem_enable}, {63'b0, |w});
            check("mem_wr", {63'b0, mem_wr}, {63'b0, w[0] && d_wr});
            check("mem_addr", {32'b0, mem_addr},
                  {32'b0, w[1] ? if_addr : (w[0] ? d_addr : 32'h0)});
            check("mem_data_in", {32'b0, mem_data_in}, {32'b0, w[0] ? d_wdata : 32'h0});
            check("if_rvalid", {63'b0, if_rvalid}, {63'b0, m_if_rv});
            check("d_rvalid", {63'b0, d_rvalid}, {63'b0, m_d_rv});
            check("if_rdata", {32'b0, if_rdata}, {32'b0, m_if_rd});
            check("d_rdata", {32'b0, d_rdata}, {32'b0, m_d_rd});
        end
    end

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        int rst_hold;
        logic [7:0] stall_seq;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 32'hA000_0000 + i;
            m_mem[i]   = 32'hA000_0000 + i;
        end
        rst_n = 1'b0; if_req = 0; if_addr = '0;
        d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        repeat (2) next_cyc();

        // Fetch held across reset release: INIT cycle denies, then grants.
        if_req = 1; if_addr = 32'h0;
        next_cyc();
        rst_n = 1'b1;
        sample();
        check("init_if_gnt", {63'b0, if_gnt}, 64'd0);
        check("init_pc_stall", {63'b0, pc_stall}, 64'd1);
        next_cyc(); sample();
        check("run_if_gnt", {63'b0, if_gnt}, 64'd1);
        next_cyc(); if_addr = 32'h4; sample();
        check("fetch0_rvalid", {63'b0, if_rvalid}, 64'd1);
        check("fetch0_rdata", {32'b0, if_rdata}, 64'hA000_0000);
        next_cyc(); if_addr = 32'h8; sample();
        check("fetch4_rdata", {32'b0, if_rdata}, 64'hA000_0001);
        next_cyc(); if_req = 0; sample();
        check("fetch8_rdata", {32'b0, if_rdata}, 64'hA000_0002);
        check("fetch8_rvalid", {63'b0, if_rvalid}, 64'd1);
        next_cyc(); sample();
        check("fetch_done_rvalid", {63'b0, if_rvalid}, 64'd0);

        // Store then load at 0x40.
        next_cyc(); d_req = 1; d_wr = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; sample();
        check("store_mem_wr", {63'b0, mem_wr}, 64'd1);
        next_cyc(); d_wr = 0; d_wdata = '0; sample();
        check("load_mem_wr", {63'b0, mem_wr}, 64'd0);
        check("store_no_rvalid", {63'b0, d_rvalid}, 64'd0);
        next_cyc(); d_req = 0; sample();
        check("load_rvalid", {63'b0, d_rvalid}, 64'd1);
        check("load_rdata", {32'b0, d_rdata}, 64'hDEAD_BEEF);

        // Both held: data x3, fetch x1, repeating.
        next_cyc(); if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h20;
        stall_seq = '0;
        for (int i = 0; i < 8; i++) begin
            sample();
            stall_seq[7-i] = pc_stall;
            if (i < 7) next_cyc();
        end
        check("starve_pattern", {56'b0, stall_seq}, 64'hEE);

        // Reset the cycle after a load grant: rvalid dropped.
        next_cyc(); if_req = 0; d_req = 1; d_wr = 0; d_addr = 32'h44; sample();
        check("pre_rst_d_gnt", {63'b0, d_gnt}, 64'd1);
        next_cyc(); rst_n = 1'b0; sample();
        check("rst_drop_rvalid", {63'b0, d_rvalid}, 64'd0);
        check("rst_drop_rdata", {32'b0, d_rdata}, 64'd0);
        next_cyc(); next_cyc();
        rst_n = 1'b1; sample();
        check("rst_init_d_gnt", {63'b0, d_gnt}, 64'd0);
        next_cyc(); sample();
        check("rst_run_d_gnt", {63'b0, d_gnt}, 64'd1);

        // Fetch withdrawn at two denials: counter restarts.
        next_cyc(); if_req = 1;
        next_cyc();
        next_cyc(); if_req = 0;
        next_cyc(); if_req = 1;
        stall_seq = '0;
        for (int i = 0; i < 4; i++) begin
            sample();
            stall_seq[3-i] = if_gnt;
            if (i < 3) next_cyc();
        end
        check("restart_pattern", {60'b0, stall_seq[3:0]}, 64'h1);

        // Randomized traffic with occasional resets.
        rst_hold = 0;
        for (int n = 0; n < 2000; n++) begin
            next_cyc();
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                rst_hold = 2;
            end
            if_req  = ($urandom_range(0, 9) < 7);
            if_addr = $urandom;
            d_req   = ($urandom_range(0, 9) < 6);
            d_wr    = $urandom_range(0, 1) == 1;
            d_addr  = {$urandom} & 32'h0000_03FC;
            d_wdata = $urandom;
        end
        next_cyc(); rst_n = 1'b1; if_req = 0; d_req = 0;
        repeat (3) next_cyc();
        sample();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported `memory2c` instance between the instruction-fetch path (PC register / adder) and the data load/store path. Grants one requester per cycle with data-side priority and a bounded-starvation guarantee for fetch. Registers read data into per-requester response ports. Drives the PC stall signal that holds the PC register while fetch is not granted.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both requesters and memory.
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 3, consecutive denied fetch cycles before fetch is forced to win (1..15).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  ADDR_W  fetch address (the PC).
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_rvalid`  out  1  `if_rdata` valid (one-cycle pulse).
- `if_rdata`  out  DATA_W  registered instruction word.
- `d_req`  in  1  data request.
- `d_wr`  in  1  1 = store, 0 = load; qualified by `d_req`.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data granted this cycle (combinational).
- `d_rvalid`  out  1  `d_rdata` valid (one-cycle pulse, loads only).
- `d_rdata`  out  DATA_W  registered load data.
- `pc_stall`  out  1  `if_req & ~if_gnt`; holds the PC register.
- `mem_enable`  out  1  to `memory2c.enable`.
- `mem_wr`  out  1  to `memory2c.wr`.
- `mem_addr`  out  ADDR_W  to `memory2c.addr`.
- `mem_data_in`  out  DATA_W  to `memory2c.data_in`.
- `mem_data_out`  in  DATA_W  from `memory2c.data_out` (combinational read).

## Operation
- FSM states: INIT, RUN.
  - Reset enters INIT.
  - INIT lasts exactly one cycle after `reset` deasserts. No grants are issued, and `memory2c` finishes its own reset.
  - INIT → RUN unconditionally. RUN holds until the next reset.
- Starvation counter `wait_cnt`:
  - Width is ceil(log2(MAX_WAIT+1)).
  - Increments when `if_req & ~if_gnt` in RUN, saturating at MAX_WAIT.
  - Clears when `if_gnt` is 1 or `if_req` is 0.
- Arbitration in RUN (combinational):
  - Only `d_req`: data wins.
  - Only `if_req`: fetch wins.
  - Both asserted: data wins unless `wait_cnt == MAX_WAIT`, in which case fetch wins.
  - Neither asserted: no grant.
- Memory mux:
  - Fetch granted: `mem_enable`=1, `mem_wr`=0, `mem_addr`=`if_addr`.
  - Data granted: `mem_enable`=1, `mem_wr`=`d_wr`, `mem_addr`=`d_addr`, `mem_data_in`=`d_wdata`.
  - No grant: `mem_enable`=0, `mem_wr`=0, `mem_addr`=0, `mem_data_in`=0.
- Responses:
  - At the grant edge, `mem_data_out` is captured into `if_rdata` or `d_rdata` (loads only).
  - The matching rvalid is set for exactly the following cycle.
  - The rdata registers hold their value until the next capture.
  - A store produces no `d_rvalid`; it completes at the grant edge.
- Requesters hold req, address, `d_wr` and `d_wdata` stable until their gnt is seen. The arbiter does not check this.

## Timing
- Reset (`reset`=0, asynchronous):
  - `wait_cnt`=0, state=INIT.
  - `if_rvalid`=`d_rvalid`=0, `if_rdata`=`d_rdata`=0.
  - All gnts, `mem_enable`, `mem_wr`, `mem_addr`, `mem_data_in` and `pc_stall` are forced to 0.
- During INIT, `pc_stall`=`if_req`.
- Grant latency: 0 cycles; gnt is combinational from req in the same cycle.
- Read latency: rvalid and rdata appear 1 cycle after the grant cycle. Throughput is 1 access per cycle.
- Fetch worst-case wait under continuous `d_req`: MAX_WAIT denied cycles, then a guaranteed grant.
- `if_rvalid` and `d_rvalid` are never both 1 in the same cycle.
- Reset mid-access: any pending rvalid is dropped. No store is issued during reset or INIT.
- `wait_cnt` does not wrap; it saturates.

## Test plan
- Reset release, `if_req`=1 held with `if_addr`=0x0 → `if_gnt`=0 and `pc_stall`=1 in the INIT cycle. Next cycle `if_gnt`=1. The cycle after, `if_rvalid`=1 with `if_rdata`=mem[0x0].
- Back-to-back fetch at 0x0, 0x4, 0x8 with no data traffic → one grant per cycle. `if_rvalid` is high for 3 consecutive cycles with the matching words.
- Store `d_addr`=0x40, `d_wdata`=0xDEADBEEF, then load 0x40 → `mem_wr`=1 only in the store cycle, no `d_rvalid` for the store. The load returns `d_rdata`=0xDEADBEEF one cycle after its grant.
- `if_req` and `d_req` held high continuously with MAX_WAIT=3 → data is granted 3 cycles, then fetch 1 cycle, repeating. `pc_stall` follows the `if_req & ~if_gnt` pattern 1,1,1,0.
- `reset` pulsed low the cycle after a load grant → `d_rvalid` stays 0 and all outputs read 0 during reset. After release, INIT lasts one cycle before any grant.
- Fetch request withdrawn at `wait_cnt`=2, then reasserted alongside `d_req` → the counter restarts from 0, so data wins the next 3 cycles.
